// File: rtl/mem_read_arbiter_if.sv
// Requester, memory-port and status signals of the shared doubleword
// read port; the arbiter takes the slave view.
interface mem_read_arbiter_if;
    logic        f_req;
    logic [0:60] f_addr;
    logic        f_gnt;
    logic        f_valid;
    logic [0:63] f_data;

    logic        d_req;
    logic [0:60] d_addr;
    logic        d_gnt;
    logic        d_valid;
    logic [0:63] d_data;

    logic [0:60] mem_addr;
    logic [0:63] mem_rdata;
    logic        busy;

    modport slave (
        input  f_req, f_addr, d_req, d_addr, mem_rdata,
        output f_gnt, f_valid, f_data,
        output d_gnt, d_valid, d_data,
        output mem_addr, busy
    );

    modport master (
        output f_req, f_addr, d_req, d_addr, mem_rdata,
        input  f_gnt, f_valid, f_data,
        input  d_gnt, d_valid, d_data,
        input  mem_addr, busy
    );
endinterface

// File: rtl/mem_read_arbiter.sv
// Shares one doubleword memory read port between fetch and load:
// load-first arbitration with a starvation guard that forces a fetch grant.
module mem_read_arbiter #(
    parameter int unsigned LATENCY      = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               reset,
    mem_read_arbiter_if.slave bus
);
    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    localparam logic [3:0] LatLoad   = 4'(LATENCY);
    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    state_e      state_q, state_d;
    logic [3:0]  lat_cnt_q, lat_cnt_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        owner_q, owner_d;
    logic [0:60] mem_addr_q, mem_addr_d;
    logic        busy_q, busy_d;
    logic        f_valid_q, f_valid_d;
    logic        d_valid_q, d_valid_d;
    logic [0:63] f_data_q, f_data_d;
    logic [0:63] d_data_q, d_data_d;

    logic        f_win;
    logic        f_gnt;
    logic        d_gnt;

    // Fetch only beats a pending load once the guard has saturated.
    always_comb begin
        f_win = bus.f_req && (!bus.d_req || starve_cnt_q == StarveMax);
        f_gnt = !reset && state_q == IDLE && f_win;
        d_gnt = !reset && state_q == IDLE && bus.d_req && !f_win;
    end

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        owner_d      = owner_q;
        mem_addr_d   = mem_addr_q;
        busy_d       = busy_q;
        f_valid_d    = 1'b0;
        d_valid_d    = 1'b0;
        f_data_d     = f_data_q;
        d_data_d     = d_data_q;

        unique case (state_q)
            IDLE: begin
                if (f_gnt || d_gnt) begin
                    state_d    = BUSY;
                    lat_cnt_d  = LatLoad;
                    owner_d    = d_gnt;
                    mem_addr_d = d_gnt ? bus.d_addr : bus.f_addr;
                    busy_d     = 1'b1;
                end
            end
            BUSY: begin
                lat_cnt_d = lat_cnt_q - 4'd1;
                if (lat_cnt_q == 4'd1) begin
                    state_d    = IDLE;
                    mem_addr_d = '0;
                    busy_d     = 1'b0;
                    if (owner_q) begin
                        d_valid_d = 1'b1;
                        d_data_d  = bus.mem_rdata;
                    end else begin
                        f_valid_d = 1'b1;
                        f_data_d  = bus.mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Counts load grants that bypassed a waiting fetch.
        if (f_gnt) begin
            starve_cnt_d = '0;
        end else if (d_gnt && bus.f_req && starve_cnt_q < StarveMax) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            owner_q      <= 1'b0;
            mem_addr_q   <= '0;
            busy_q       <= 1'b0;
            f_valid_q    <= 1'b0;
            d_valid_q    <= 1'b0;
            f_data_q     <= '0;
            d_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
            mem_addr_q   <= mem_addr_d;
            busy_q       <= busy_d;
            f_valid_q    <= f_valid_d;
            d_valid_q    <= d_valid_d;
            f_data_q     <= f_data_d;
            d_data_q     <= d_data_d;
        end
    end

    assign bus.f_gnt    = f_gnt;
    assign bus.d_gnt    = d_gnt;
    assign bus.f_valid  = f_valid_q;
    assign bus.d_valid  = d_valid_q;
    assign bus.f_data   = f_data_q;
    assign bus.d_data   = d_data_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.busy     = busy_q;

    a_one_gnt: assert property (
        @(posedge clk) disable iff (reset) !(f_gnt && d_gnt));
    a_one_valid: assert property (
        @(posedge clk) disable iff (reset) !(f_valid_q && d_valid_q));
    a_gnt_needs_req: assert property (
        @(posedge clk) disable iff (reset)
        (!f_gnt || bus.f_req) && (!d_gnt || bus.d_req));
endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: directed scenarios on a LATENCY=1 and a
// LATENCY=3 instance, then random traffic against a transaction-level model.
module tb_mem_read_arbiter;
    localparam int L0 = 1;
    localparam int S0 = 4;
    localparam int L1 = 3;
    localparam int S1 = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic        r_f[2], r_d[2];
    logic [60:0] a_f[2], a_d[2];
    logic        o_fg[2], o_dg[2], o_fv[2], o_dv[2], o_busy[2];
    logic [63:0] o_fd[2], o_dd[2];
    logic [60:0] o_ma[2];

    mem_read_arbiter_if i0 ();
    mem_read_arbiter_if i1 ();

    mem_read_arbiter #(.LATENCY(L0), .STARVE_LIMIT(S0)) u0 (
        .clk(clk), .reset(reset), .bus(i0.slave));
    mem_read_arbiter #(.LATENCY(L1), .STARVE_LIMIT(S1)) u1 (
        .clk(clk), .reset(reset), .bus(i1.slave));

    // Memory contents as a pure function of the doubleword address.
    function automatic logic [63:0] memf(input logic [60:0] a);
        if (a == 61'h10) return 64'hDEADBEEF00000001;
        return {a[28:0], 3'b101, 32'hC0DE0000 ^ a[31:0]};
    endfunction

    assign i0.mem_rdata = memf(i0.mem_addr);
    assign i1.mem_rdata = memf(i1.mem_addr);
    assign i0.f_req = r_f[0];
    assign i0.f_addr = a_f[0];
    assign i0.d_req = r_d[0];
    assign i0.d_addr = a_d[0];
    assign i1.f_req = r_f[1];
    assign i1.f_addr = a_f[1];
    assign i1.d_req = r_d[1];
    assign i1.d_addr = a_d[1];
    assign o_fg[0] = i0.f_gnt;
    assign o_dg[0] = i0.d_gnt;
    assign o_fv[0] = i0.f_valid;
    assign o_dv[0] = i0.d_valid;
    assign o_fd[0] = i0.f_data;
    assign o_dd[0] = i0.d_data;
    assign o_ma[0] = i0.mem_addr;
    assign o_busy[0] = i0.busy;
    assign o_fg[1] = i1.f_gnt;
    assign o_dg[1] = i1.d_gnt;
    assign o_fv[1] = i1.f_valid;
    assign o_dv[1] = i1.d_valid;
    assign o_fd[1] = i1.f_data;
    assign o_dd[1] = i1.d_data;
    assign o_ma[1] = i1.mem_addr;
    assign o_busy[1] = i1.busy;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < 2; k++) begin
            r_f[k] = 1'b0;
            r_d[k] = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            r_f[k] = 1'b1;
            r_d[k] = 1'b1;
            a_f[k] = 61'h5;
            a_d[k] = 61'h6;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({o_fg[k], o_dg[k], o_fv[k], o_dv[k], o_busy[k]} !== 5'b0 ||
                o_ma[k] !== '0 || o_fd[k] !== '0 || o_dd[k] !== '0) begin
                n_errors++;
                $display("FAIL reset[%0d]: gnt=%b%b valid=%b%b busy=%b ma=%h fd=%h dd=%h, required all 0",
                         k, o_fg[k], o_dg[k], o_fv[k], o_dv[k], o_busy[k],
                         o_ma[k], o_fd[k], o_dd[k]);
            end
        end
        next_cycle();
        clear_reqs();
        reset = 1'b0;
    endtask

    task automatic test_single_fetch();
        logic efg, efv, eb;
        logic [60:0] ema;
        for (int c = 0; c <= 3; c++) begin
            next_cycle();
            r_f[0] = (c == 0);
            a_f[0] = 61'h10;
            @(negedge clk);
            efg = (c == 0);
            efv = (c == 2);
            eb  = (c == 1);
            ema = eb ? 61'h10 : 61'h0;
            n_checks++;
            if ({o_fg[0], o_dg[0]} !== {efg, 1'b0}) begin
                n_errors++;
                $display("FAIL single_fetch gnt c%0d: got f/d %b%b, required %b0",
                         c, o_fg[0], o_dg[0], efg);
            end
            n_checks++;
            if ({o_fv[0], o_dv[0], o_busy[0]} !== {efv, 1'b0, eb} || o_ma[0] !== ema) begin
                n_errors++;
                $display("FAIL single_fetch bus c%0d: got fv/dv/busy %b%b%b ma %h, required %b0%b ma %h",
                         c, o_fv[0], o_dv[0], o_busy[0], o_ma[0], efv, eb, ema);
            end
            if (c >= 2) begin
                n_checks++;
                if (o_fd[0] !== 64'hDEADBEEF00000001) begin
                    n_errors++;
                    $display("FAIL single_fetch data c%0d: got %h, required DEADBEEF00000001",
                             c, o_fd[0]);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic efg, edg, efv, edv, eb;
        logic [60:0] ema;
        for (int c = 0; c <= 4; c++) begin
            next_cycle();
            if (c == 0) begin
                r_f[0] = 1'b1; a_f[0] = 61'h20;
                r_d[0] = 1'b1; a_d[0] = 61'h40;
            end
            if (c == 1) r_d[0] = 1'b0;
            if (c == 3) r_f[0] = 1'b0;
            @(negedge clk);
            edg = (c == 0);
            efg = (c == 2);
            edv = (c == 2);
            efv = (c == 4);
            eb  = (c == 1) || (c == 3);
            ema = (c == 1) ? 61'h40 : (c == 3) ? 61'h20 : 61'h0;
            n_checks++;
            if ({o_fg[0], o_dg[0], o_fv[0], o_dv[0], o_busy[0]} !== {efg, edg, efv, edv, eb} ||
                o_ma[0] !== ema) begin
                n_errors++;
                $display("FAIL simultaneous c%0d: got g %b%b v %b%b busy %b ma %h, required g %b%b v %b%b busy %b ma %h",
                         c, o_fg[0], o_dg[0], o_fv[0], o_dv[0], o_busy[0], o_ma[0],
                         efg, edg, efv, edv, eb, ema);
            end
        end
        n_checks++;
        if (o_dd[0] !== memf(61'h40) || o_fd[0] !== memf(61'h20)) begin
            n_errors++;
            $display("FAIL simultaneous data: got d %h f %h, required d %h f %h",
                     o_dd[0], o_fd[0], memf(61'h40), memf(61'h20));
        end
    endtask

    task automatic test_starvation();
        logic efg, edg, efv, edv;
        for (int c = 0; c <= 20; c++) begin
            next_cycle();
            if (c == 0) begin
                r_f[0] = 1'b1; a_f[0] = 61'h21;
                r_d[0] = 1'b1; a_d[0] = 61'h41;
            end
            if (c == 19) clear_reqs();
            @(negedge clk);
            // Every fifth grant goes to fetch.
            efg = (c % 2 == 0) && c <= 18 && ((c / 2) % 5 == 4);
            edg = (c % 2 == 0) && c <= 18 && ((c / 2) % 5 != 4);
            efv = (c % 2 == 0) && c >= 2 && (((c / 2) - 1) % 5 == 4);
            edv = (c % 2 == 0) && c >= 2 && (((c / 2) - 1) % 5 != 4);
            n_checks++;
            if ({o_fg[0], o_dg[0], o_fv[0], o_dv[0]} !== {efg, edg, efv, edv}) begin
                n_errors++;
                $display("FAIL starvation c%0d: got g %b%b v %b%b, required g %b%b v %b%b",
                         c, o_fg[0], o_dg[0], o_fv[0], o_dv[0], efg, edg, efv, edv);
            end
        end
    endtask

    task automatic test_latency3();
        logic efg, edg, efv, edv, eb;
        logic [60:0] ema;
        for (int c = 0; c <= 8; c++) begin
            next_cycle();
            if (c == 0) begin r_d[1] = 1'b1; a_d[1] = 61'h7; end
            if (c == 1) begin r_d[1] = 1'b0; r_f[1] = 1'b1; a_f[1] = 61'h33; end
            if (c == 5) r_f[1] = 1'b0;
            @(negedge clk);
            edg = (c == 0);
            efg = (c == 4);
            edv = (c == 4);
            efv = (c == 8);
            eb  = (c >= 1 && c <= 3) || (c >= 5 && c <= 7);
            ema = (c >= 1 && c <= 3) ? 61'h7 : (c >= 5 && c <= 7) ? 61'h33 : 61'h0;
            n_checks++;
            if ({o_fg[1], o_dg[1], o_fv[1], o_dv[1], o_busy[1]} !== {efg, edg, efv, edv, eb} ||
                o_ma[1] !== ema) begin
                n_errors++;
                $display("FAIL latency3 c%0d: got g %b%b v %b%b busy %b ma %h, required g %b%b v %b%b busy %b ma %h",
                         c, o_fg[1], o_dg[1], o_fv[1], o_dv[1], o_busy[1], o_ma[1],
                         efg, edg, efv, edv, eb, ema);
            end
        end
        n_checks++;
        if (o_dd[1] !== memf(61'h7) || o_fd[1] !== memf(61'h33)) begin
            n_errors++;
            $display("FAIL latency3 data: got d %h f %h, required d %h f %h",
                     o_dd[1], o_fd[1], memf(61'h7), memf(61'h33));
        end
    endtask

    task automatic test_withdrawn();
        logic efg, edg, efv, edv, eb;
        logic [60:0] ema;
        for (int c = 0; c <= 14; c++) begin
            next_cycle();
            case (c)
                0: begin
                    r_f[0] = 1'b1; a_f[0] = 61'h11;
                    r_d[0] = 1'b1; a_d[0] = 61'h12;
                end
                1: clear_reqs();
                3: begin r_d[0] = 1'b1; a_d[0] = 61'h13; end
                4: begin r_d[0] = 1'b0; r_f[0] = 1'b1; a_f[0] = 61'h14; end
                5: r_f[0] = 1'b0;
                6: begin
                    r_f[0] = 1'b1; a_f[0] = 61'h15;
                    r_d[0] = 1'b1; a_d[0] = 61'h16;
                end
                13: clear_reqs();
                default: ;
            endcase
            @(negedge clk);
            // Guard stays at 1 across the withdrawn fetch: three loads, then fetch.
            edg = (c == 0) || (c == 3) || (c == 6) || (c == 8) || (c == 10);
            efg = (c == 12);
            edv = (c == 2) || (c == 5) || (c == 8) || (c == 10) || (c == 12);
            efv = (c == 14);
            eb  = (c == 1) || (c == 4) || (c == 7) || (c == 9) || (c == 11) || (c == 13);
            ema = (c == 1) ? 61'h12 : (c == 4) ? 61'h13 :
                  (c == 13) ? 61'h15 : eb ? 61'h16 : 61'h0;
            n_checks++;
            if ({o_fg[0], o_dg[0], o_fv[0], o_dv[0], o_busy[0]} !== {efg, edg, efv, edv, eb} ||
                o_ma[0] !== ema) begin
                n_errors++;
                $display("FAIL withdrawn c%0d: got g %b%b v %b%b busy %b ma %h, required g %b%b v %b%b busy %b ma %h",
                         c, o_fg[0], o_dg[0], o_fv[0], o_dv[0], o_busy[0], o_ma[0],
                         efg, edg, efv, edv, eb, ema);
            end
        end
        n_checks++;
        if (o_fd[0] !== memf(61'h15)) begin
            n_errors++;
            $display("FAIL withdrawn data: got %h, required %h", o_fd[0], memf(61'h15));
        end
    endtask

    task automatic test_reset_mid();
        logic efg, efv, eb;
        logic [60:0] ema;
        for (int c = 0; c <= 6; c++) begin
            next_cycle();
            if (c == 0) begin r_f[0] = 1'b1; a_f[0] = 61'h55; end
            if (c == 1) begin
                r_f[0] = 1'b0;
                reset = 1'b1;
                #1;
                n_checks++;
                if (o_busy[0] !== 1'b0 || o_ma[0] !== '0 || o_fd[0] !== '0 || o_dd[0] !== '0) begin
                    n_errors++;
                    $display("FAIL reset_mid immediate: got busy %b ma %h fd %h dd %h, required all 0",
                             o_busy[0], o_ma[0], o_fd[0], o_dd[0]);
                end
            end
            if (c == 3) reset = 1'b0;
            if (c == 4) begin r_f[0] = 1'b1; a_f[0] = 61'h66; end
            if (c == 5) r_f[0] = 1'b0;
            @(negedge clk);
            efg = (c == 0) || (c == 4);
            efv = (c == 6);
            eb  = (c == 5);
            ema = eb ? 61'h66 : 61'h0;
            n_checks++;
            if ({o_fg[0], o_dg[0], o_fv[0], o_dv[0], o_busy[0]} !== {efg, 1'b0, efv, 1'b0, eb} ||
                o_ma[0] !== ema) begin
                n_errors++;
                $display("FAIL reset_mid c%0d: got g %b%b v %b%b busy %b ma %h, required g %b0 v %b0 busy %b ma %h",
                         c, o_fg[0], o_dg[0], o_fv[0], o_dv[0], o_busy[0], o_ma[0],
                         efg, efv, eb, ema);
            end
        end
        n_checks++;
        if (o_fd[0] !== memf(61'h66)) begin
            n_errors++;
            $display("FAIL reset_mid data: got %h, required %h", o_fd[0], memf(61'h66));
        end
    endtask

    task automatic test_random();
        int          lat[2] = '{L0, L1};
        int          lim[2] = '{S0, S1};
        bit          has[2];
        int          gc[2];
        bit          own_d[2];
        logic [60:0] taddr[2];
        int          starve[2];
        logic [63:0] efd[2], edd[2];
        logic        lg_f[2], lg_d[2];
        logic        idle, eb, efv, edv, efg, edg;
        logic [60:0] ema;

        next_cycle();
        clear_reqs();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            has[k] = 1'b0; gc[k] = 0; own_d[k] = 1'b0; taddr[k] = '0;
            starve[k] = 0; efd[k] = '0; edd[k] = '0;
            lg_f[k] = 1'b0; lg_d[k] = 1'b0;
        end

        for (int c = 0; c < 600; c++) begin
            next_cycle();
            for (int k = 0; k < 2; k++) begin
                if (r_f[k] && !lg_f[k]) begin
                    if ($urandom_range(7) == 0) r_f[k] = 1'b0;
                end else begin
                    r_f[k] = 1'($urandom_range(1));
                    a_f[k] = 61'($urandom);
                end
                if (r_d[k] && !lg_d[k]) begin
                    if ($urandom_range(7) == 0) r_d[k] = 1'b0;
                end else begin
                    r_d[k] = ($urandom_range(3) != 0);
                    a_d[k] = 61'($urandom);
                end
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                // A grant at cycle g occupies g+1..g+lat and returns at g+lat+1.
                idle = !has[k] || (c >= gc[k] + lat[k] + 1);
                eb   = has[k] && c > gc[k] && c <= gc[k] + lat[k];
                ema  = eb ? taddr[k] : 61'h0;
                efv  = has[k] && c == gc[k] + lat[k] + 1 && !own_d[k];
                edv  = has[k] && c == gc[k] + lat[k] + 1 && own_d[k];
                if (efv) efd[k] = memf(taddr[k]);
                if (edv) edd[k] = memf(taddr[k]);
                efg = idle && r_f[k] && (!r_d[k] || starve[k] == lim[k]);
                edg = idle && r_d[k] && !efg;

                n_checks++;
                if ({o_fg[k], o_dg[k]} !== {efg, edg}) begin
                    n_errors++;
                    $display("FAIL random[%0d] gnt c%0d: got f/d %b%b, required %b%b",
                             k, c, o_fg[k], o_dg[k], efg, edg);
                end
                n_checks++;
                if ({o_fv[k], o_dv[k], o_busy[k]} !== {efv, edv, eb} || o_ma[k] !== ema) begin
                    n_errors++;
                    $display("FAIL random[%0d] bus c%0d: got v %b%b busy %b ma %h, required v %b%b busy %b ma %h",
                             k, c, o_fv[k], o_dv[k], o_busy[k], o_ma[k], efv, edv, eb, ema);
                end
                n_checks++;
                if (o_fd[k] !== efd[k] || o_dd[k] !== edd[k]) begin
                    n_errors++;
                    $display("FAIL random[%0d] data c%0d: got f %h d %h, required f %h d %h",
                             k, c, o_fd[k], o_dd[k], efd[k], edd[k]);
                end

                if (efg || edg) begin
                    has[k]   = 1'b1;
                    gc[k]    = c;
                    own_d[k] = edg;
                    taddr[k] = edg ? a_d[k] : a_f[k];
                    if (efg) starve[k] = 0;
                    else if (r_f[k] && starve[k] < lim[k]) starve[k]++;
                end
                lg_f[k] = o_fg[k];
                lg_d[k] = o_dg[k];
            end
        end
        next_cycle();
        clear_reqs();
        repeat (8) next_cycle();
    endtask

    initial begin
        clear_reqs();
        for (int k = 0; k < 2; k++) begin
            a_f[k] = '0;
            a_d[k] = '0;
        end
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_latency3();
        test_withdrawn();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
